// File: rtl/regfile_mp.sv
// Multi-port register file: 2 combinational bypassed reads, 2 writes, busy scoreboard, clear-on-reset.
// Latency: reads and busy are combinational (same-cycle bypass); writes and issues take effect at the next posedge.
// Backpressure: none; ready stays low for DEPTH cycles after reset while entries clear, and traffic is ignored then.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  // One extra bit so the terminal index is compared without wrapping to 0.
  logic [ADDR_W:0]   r_clr_idx;
  logic [ADDR_W:0]   w_clr_idx_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_run;
  logic              w_we1_ok;
  logic              w_we2_ok;
  logic              w_wr_hit1;
  logic              w_wr_hit2;

  assign w_run    = (r_state == S_RUN);
  assign ready    = w_run;
  // Writes to a hardwired-zero entry 0 are dropped outright.
  assign w_we1_ok = w_run && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign w_we2_ok = w_run && we2 && !((ZERO_REG != 0) && (waddr2 == '0));

  // FSM state and clear index register; reset restarts the clear at entry 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next state: walk every entry once, then stay in RUN until reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    if (r_state == S_CLEAR) begin
      w_clr_idx_nxt = r_clr_idx + 1'b1;
      if (r_clr_idx == LAST_IDX) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  // Storage: clear sequencer in CLEAR, port 1 then port 2 in RUN so port 2 wins a collision.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx[ADDR_W-1:0]] <= '0;
    end else begin
      if (w_we1_ok) r_mem[waddr1] <= wdata1;
      if (w_we2_ok) r_mem[waddr2] <= wdata2;
    end
  end

  // Scoreboard next value: writebacks clear, then issue sets (newer producer wins).
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      if (we1) w_busy_nxt[waddr1] = 1'b0;
      if (we2) w_busy_nxt[waddr2] = 1'b0;
      if (issue_valid) w_busy_nxt[issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Read port 1 with bypass: zero reg, then port 2, then port 1, then storage.
  always_comb begin
    rdata1 = '0;
    if (w_run) begin
      if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
      else if (we2 && (waddr2 == raddr1))   rdata1 = wdata2;
      else if (we1 && (waddr1 == raddr1))   rdata1 = wdata1;
      else                                  rdata1 = r_mem[raddr1];
    end
  end

  // Read port 2, same priority as port 1.
  always_comb begin
    rdata2 = '0;
    if (w_run) begin
      if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2 = '0;
      else if (we2 && (waddr2 == raddr2))   rdata2 = wdata2;
      else if (we1 && (waddr1 == raddr2))   rdata2 = wdata1;
      else                                  rdata2 = r_mem[raddr2];
    end
  end

  // A register being written back this cycle reads as not busy; the bypass supplies its value.
  assign w_wr_hit1 = (we1 && (waddr1 == raddr1)) || (we2 && (waddr2 == raddr1));
  assign w_wr_hit2 = (we1 && (waddr1 == raddr2)) || (we2 && (waddr2 == raddr2));
  assign busy1     = w_run && r_busy[raddr1] && !w_wr_hit1;
  assign busy2     = w_run && r_busy[raddr2] && !w_wr_hit2;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, bypass, port priority, zero reg, scoreboard, mid-clear reset.
// Inputs change 1 time unit after each posedge; outputs are checked 2 units after the posedge.
// No backpressure; every wait is a fixed cycle count.
module tb_regfile_mp;

  logic        clk;
  logic        resetn;
  logic [4:0]  raddr1, raddr2, waddr1, waddr2, issue_addr;
  logic [31:0] rdata1, rdata2, wdata1, wdata2;
  logic        we1, we2, issue_valid;
  logic        busy1, busy2, ready;

  int checks;
  int errors;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .resetn(resetn),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one posedge; inputs may be changed right after it returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle time before looking at combinational outputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    we1 = 1'b0; we2 = 1'b0; issue_valid = 1'b0;
    waddr1 = '0; waddr2 = '0; wdata1 = '0; wdata2 = '0; issue_addr = '0;
  endtask

  // Release reset away from an edge and expect ready exactly at the 32nd posedge.
  task automatic release_and_count(input string tag);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      settle();
      check($sformatf("%s_ready_p%0d", tag, i), {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    idle_inputs();

    // Reset state.
    #12;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_busy1", {31'b0, busy1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);

    // First bring-up, then preload entry 12 so the next clear can be seen to wipe it.
    release_and_count("clr0");
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    raddr1 = 5'd12;
    settle();
    check("preload12", rdata1, 32'hDEAD_BEEF);

    // Second reset: clear must wipe preloaded data.
    @(negedge clk);
    resetn = 1'b0;
    #3;
    check("rst2_ready", {31'b0, ready}, 32'd0);
    release_and_count("clr1");
    raddr1 = 5'd12; raddr2 = 5'd31;
    settle();
    check("cleared12", rdata1, 32'd0);
    check("cleared31", rdata2, 32'd0);

    // Same-cycle bypass on port 1 write, then stored value.
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h1234_5678; raddr1 = 5'd5;
    settle();
    check("bypass5", rdata1, 32'h1234_5678);
    step();
    idle_inputs();
    settle();
    check("stored5", rdata1, 32'h1234_5678);

    // Both ports write address 7: port 2 wins, in the cycle and afterwards.
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hAAAA_AAAA;
    we2 = 1'b1; waddr2 = 5'd7; wdata2 = 32'h5555_5555;
    raddr1 = 5'd7;
    settle();
    check("both7_bypass", rdata1, 32'h5555_5555);
    step();
    idle_inputs();
    raddr2 = 5'd5;
    settle();
    check("both7_stored", rdata1, 32'h5555_5555);
    check("port2_read5", rdata2, 32'h1234_5678);

    // Port 1 bypass seen on read port 2 for a different address.
    we1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'h0BAD_F00D; raddr2 = 5'd20;
    settle();
    check("bypass20_p2", rdata2, 32'h0BAD_F00D);
    step();
    idle_inputs();

    // Hardwired zero register: writes and issues to 0 have no effect.
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF; raddr1 = 5'd0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    settle();
    check("zero_bypass", rdata1, 32'd0);
    step();
    idle_inputs();
    settle();
    check("zero_stored", rdata1, 32'd0);
    check("zero_busy", {31'b0, busy1}, 32'd0);

    // Scoreboard: issue 3 at T, busy from T+1, cleared by port 2 writeback at T+4.
    issue_valid = 1'b1; issue_addr = 5'd3; raddr1 = 5'd3;
    settle();
    check("sb3_T", {31'b0, busy1}, 32'd0);
    step();
    idle_inputs();
    settle();
    check("sb3_T1", {31'b0, busy1}, 32'd1);
    step();
    settle();
    check("sb3_T2", {31'b0, busy1}, 32'd1);
    step();
    settle();
    check("sb3_T3", {31'b0, busy1}, 32'd1);
    step();
    we2 = 1'b1; waddr2 = 5'd3; wdata2 = 32'hCAFE_0003;
    settle();
    check("sb3_T4_busy", {31'b0, busy1}, 32'd0);
    check("sb3_T4_data", rdata1, 32'hCAFE_0003);
    step();
    idle_inputs();
    settle();
    check("sb3_T5", {31'b0, busy1}, 32'd0);

    // Issue and writeback to 9 in the same cycle: set wins.
    issue_valid = 1'b1; issue_addr = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h9999_0009; raddr2 = 5'd9;
    settle();
    check("sb9_T", {31'b0, busy2}, 32'd0);
    step();
    idle_inputs();
    settle();
    check("sb9_T1", {31'b0, busy2}, 32'd1);
    check("sb9_data", rdata2, 32'h9999_0009);

    // Mid-clear reset at clr_idx=10, with write/issue attempts during CLEAR.
    @(negedge clk);
    resetn = 1'b0;
    #3;
    check("rst3_busy2", {31'b0, busy2}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    resetn = 1'b0;
    we1 = 1'b1; waddr1 = 5'd20; wdata1 = 32'h7777_7777;
    we2 = 1'b1; waddr2 = 5'd21; wdata2 = 32'h6666_6666;
    issue_valid = 1'b1; issue_addr = 5'd22;
    raddr1 = 5'd20; raddr2 = 5'd22;
    #3;
    check("midclr_rdata_forced", rdata1, 32'd0);
    release_and_count("clr2");
    idle_inputs();
    raddr1 = 5'd20; raddr2 = 5'd21;
    settle();
    check("midclr_entry20", rdata1, 32'd0);
    check("midclr_entry21", rdata2, 32'd0);
    raddr1 = 5'd22;
    settle();
    check("midclr_busy22", {31'b0, busy1}, 32'd0);
    raddr1 = 5'd5;
    settle();
    check("midclr_entry5", rdata1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
